// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one fulladder cell.
// Operands are captured on an accepted start and fed LSB-first through the
// full adder, one bit per clock, with the carry held in a flip-flop.
// The result appears on sum/cout together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed
// overflow output ovf.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Single-bit sum and carry
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_cout;

  // The adder cell always sees the current LSBs and the stored carry
  fulladder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath: capture on start, shift one bit per RUN cycle
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        part_d  = {fa_sum, part_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, part_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB differs from carry out of it on overflow
          ovf_d   = carry_q ^ fa_cout;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and all registered outputs; reset aborts any add in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
